// File: rtl/phy_pkg.sv
// Shared definitions for the clockless PHY serial link.
// The transmit parallel-to-serial stage and the receive deframer both import it.
//   COMMA_CHAR         : idle / alignment character, sent whenever lane valid is low
//   DEFAULT_LOCK_COUNT : consecutive aligned commas needed before the receiver locks
//   phy_state_t        : receive deframer state encoding (also exported for debug)
package phy_pkg;

    localparam logic [7:0] COMMA_CHAR         = 8'hBC;
    localparam int         DEFAULT_LOCK_COUNT = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } phy_state_t;

endpackage

// File: rtl/serial_rx_deframer_if.sv
// Bundle of the deframer's link-side signals.
//   serial_in   : serial bit stream, MSB first, one bit per clk_8f
//   data_out    : last deserialized character
//   valid_out   : data_out is payload rather than idle comma
//   word_strobe : one-cycle pulse when data_out / valid_out update
//   active      : link locked (sticky until reset)
//   state_out   : deframer state for debug
// master = the side that sources the serial stream and consumes the words,
// slave  = the deframer itself.
interface serial_rx_deframer_if #(
    parameter int DATA_WIDTH = 8
);

    logic                  serial_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  word_strobe;
    logic                  active;
    logic [1:0]            state_out;

    modport master (
        output serial_in,
        input  data_out,
        input  valid_out,
        input  word_strobe,
        input  active,
        input  state_out
    );

    modport slave (
        input  serial_in,
        output data_out,
        output valid_out,
        output word_strobe,
        output active,
        output state_out
    );

endinterface

// File: rtl/phy_bit_counter.sv
// Mod-DATA_WIDTH bit position counter with synchronous clear.
//   clk      : bit-rate clock
//   reset    : synchronous active-high reset
//   clear    : hold the count at zero (the current edge is a word boundary)
//   boundary : high while the count is DATA_WIDTH-1, i.e. the next edge
//              samples the LSB of a word
module phy_bit_counter #(
    parameter int DATA_WIDTH = 8,
    parameter int CW         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic boundary
);

    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic [CW-1:0] count;

    // Explicit wrap at LAST so non-power-of-two widths still cycle correctly.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign boundary = (count == LAST);

endmodule

// File: rtl/serial_rx_deframer.sv
// Receive-side deframer of the PHY serial link.
// Slides bit by bit looking for the comma, confirms LOCK_COUNT aligned commas,
// then deserializes every following word at the locked alignment.
//   clk_8f : sole clock, one serial bit per cycle
//   reset  : synchronous active-high reset
//   link   : slave side of serial_rx_deframer_if (serial_in in; data_out,
//            valid_out, word_strobe, active, state_out out)
module serial_rx_deframer
    import phy_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] COMMA      = COMMA_CHAR,
    parameter int                    LOCK_COUNT = DEFAULT_LOCK_COUNT
) (
    input  logic                clk_8f,
    input  logic                reset,
    serial_rx_deframer_if.slave link
);

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    phy_state_t            state_q, state_d;
    logic [3:0]            comma_cnt_q, comma_cnt_d;
    logic [DATA_WIDTH-2:0] sr_q;
    logic [DATA_WIDTH-1:0] word;
    logic                  is_comma;
    logic                  boundary;
    logic                  cnt_clear;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  strobe_q, strobe_d;

    // Only the newest DATA_WIDTH-1 bits need storing; together with the
    // incoming bit they form the word as it will look after this edge, so
    // decisions and data capture happen on the edge that samples the LSB.
    assign word     = {sr_q, link.serial_in};
    assign is_comma = (word == COMMA);

    phy_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bit_counter (
        .clk      (clk_8f),
        .reset    (reset),
        .clear    (cnt_clear),
        .boundary (boundary)
    );

    // State, comma count, shift path and output registers.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state_q     <= SEARCH;
            comma_cnt_q <= '0;
            sr_q        <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            sr_q        <= word[DATA_WIDTH-2:0];
            data_q      <= data_d;
            valid_q     <= valid_d;
            strobe_q    <= strobe_d;
        end
    end

    // Next-state and output decode.  The bit counter is held at zero while
    // searching, so a comma hit in SEARCH makes that edge the word boundary.
    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        strobe_d    = 1'b0;
        cnt_clear   = 1'b0;
        unique case (state_q)
            SEARCH: begin
                cnt_clear = 1'b1;
                if (is_comma) begin
                    comma_cnt_d = 4'd1;
                    state_d     = (LOCK_COUNT == 1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        if (comma_cnt_q + 4'd1 >= LOCK_CNT) begin
                            comma_cnt_d = LOCK_CNT;
                            state_d     = ACTIVE;
                        end else begin
                            comma_cnt_d = comma_cnt_q + 4'd1;
                        end
                    end else begin
                        comma_cnt_d = '0;
                        state_d     = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    data_d   = word;
                    valid_d  = !is_comma;
                    strobe_d = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    assign link.data_out    = data_q;
    assign link.valid_out   = valid_q;
    assign link.word_strobe = strobe_q;
    assign link.active      = (state_q == ACTIVE);
    assign link.state_out   = state_q;

endmodule

// File: doc/serial_rx_deframer.md
Name: serial_rx_deframer

Overview:
- Receive end of the clockless PHY serial link: the block that consumes what the transmit-side parallel-to-serial stage emits.
- Samples the 1-bit serial stream at clk_8f and aligns to the comma character (8'hBC), which the transmitter sends whenever its lane valid is low.
- After LOCK_COUNT consecutive aligned commas it declares the link active, then deserializes each 8-bit word.
- Non-comma words are presented as valid data. Output feeds the lane demux / byte-unstriping stage.

Parameters:
- DATA_WIDTH, 8, serial word width (bits per character).
- COMMA, 8'hBC, idle/alignment character.
- LOCK_COUNT, 4, consecutive aligned commas required to enter ACTIVE (legal range 1..15).

Ports:
- clk_8f  input  1  sole clock, bit rate.
- reset  input  1  synchronous, active-high reset.
- serial_in  input  1  serial data, MSB first, one bit per clk_8f.
- data_out  output  DATA_WIDTH  last deserialized character.
- valid_out  output  1  data_out is payload (not comma), held for one word period.
- word_strobe  output  1  one-cycle pulse when data_out/valid_out update.
- active  output  1  link locked; sticky until reset.
- state_out  output  2  current FSM state, for debug (SEARCH=0, ALIGN=1, ACTIVE=2).

Behaviour:
- Clock and reset:
  - Single clock clk_8f.
  - Reset is synchronous and active-high, sampled on the rising edge of clk_8f.
  - While reset=1, on each edge: shift register=0, bit_cnt=0, comma_cnt=0, state=SEARCH, data_out=0, valid_out=0, word_strobe=0, active=0.
- Shift path:
  - Each edge: sr <= {sr[DATA_WIDTH-2:0], serial_in}.
  - word = {sr[DATA_WIDTH-2:0], serial_in}, i.e. the value sr takes after this edge.
- SEARCH:
  - Every edge, compare word to COMMA (bit-level sliding search).
  - On match: bit_cnt <= 0 (this edge is a word boundary), comma_cnt <= 1, go to ALIGN.
  - If LOCK_COUNT==1, go directly to ACTIVE and set active.
- ALIGN:
  - bit_cnt increments mod DATA_WIDTH each edge; a boundary occurs when bit_cnt==DATA_WIDTH-1.
  - At a boundary with word==COMMA: comma_cnt++. When comma_cnt reaches LOCK_COUNT, go to ACTIVE and set active=1 on that same edge.
  - At a boundary with word!=COMMA: comma_cnt <= 0, return to SEARCH. The sliding search resumes on the next edge.
  - Between boundaries, word contents are ignored.
- ACTIVE:
  - At each boundary: data_out <= word; valid_out <= (word != COMMA); word_strobe <= 1 for exactly one cycle.
  - data_out and valid_out hold for the full DATA_WIDTH-cycle word period.
  - The first data_out update is the boundary after the locking comma.
  - No loss-of-lock detection: ACTIVE and active persist until reset.
- Latency: data_out updates on the same edge that samples the word's LSB (0 cycles after the last bit).
- Outputs outside ACTIVE: data_out=0, valid_out=0, word_strobe=0.
- Boundary conditions:
  - Reset mid-word discards the partial word. Realignment requires a fresh comma sequence.
  - A comma pattern appearing misaligned while in ACTIVE has no effect (no realignment).
  - Width rule: comma_cnt is 4 bits and saturates at LOCK_COUNT. bit_cnt is $clog2(DATA_WIDTH) bits and wraps.
  - Payload 8'hBC cannot be distinguished from idle. This is a protocol limit: it is reported as valid_out=0.

Decomposition:
- Shared package phy_pkg holds:
  - COMMA_CHAR = 8'hBC
  - the state encoding (SEARCH, ALIGN, ACTIVE)
  - default LOCK_COUNT
- The same package is used by the transmit parallel-to-serial stage.
- One natural sub-module: phy_bit_counter, a mod-DATA_WIDTH counter with synchronous clear, producing the boundary flag.
- FSM, comparator and output registers stay in the top.

Test Plan:
- Reset held 4 cycles, then serial 0s → all outputs 0, state_out=0.
- Sixteen aligned 8'hBC words, then 8'hA4, 8'h32 → after the 4th comma's LSB edge active=1, state_out=2. Next boundaries give data_out=A4 then 32 with valid_out=1; word_strobe pulses every 8 cycles.
- Three garbage bits then 4 commas (misaligned start) → lock achieved, active rises exactly 32 cycles after the first comma's MSB; following 8'hFF is received as FF, valid=1.
- Commas BC,BC,BC then 8'h00 then 4×BC, 8'hEE → returns to SEARCH on 00 (active stays 0). Locks on the second run; EE is received valid.
- ACTIVE, stream FF,BC,DD → data_out FF/valid 1, BC/valid 0, DD/valid 1.
- Assert reset for 1 cycle mid-word during ACTIVE → next edge all outputs 0, state SEARCH. Requires 4 new commas before data resumes.
